// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// INT0/INT1 states exist only when IF_STAGE_INT_EN is defined.
package if_stage_pkg;

  typedef enum logic [2:0] {
    BOOT0     = 3'd0,
    BOOT1     = 3'd1,
    FETCH     = 3'd2,
    FETCH_IMM = 3'd3
`ifdef IF_STAGE_INT_EN
    ,
    INT0      = 3'd4,
    INT1      = 3'd5
`endif
  } if_state_t;

  localparam logic [2:0]  IMM_CLASS      = 3'b010;
  localparam logic [31:0] RESET_VEC_ADDR = 32'd0;
  localparam logic [31:0] INT_VEC_ADDR   = 32'd2;

  // Instructions whose top three bits match IMM_CLASS carry a trailing immediate word.
  function automatic logic is_two_word(input logic [15:0] instr);
    return instr[15:13] == IMM_CLASS;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// 32-bit program counter with full load, half-word loads, increment and hold.
module pc_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        load,
  input  logic        load_hi,
  input  logic        load_lo,
  input  logic [31:0] load_val,
  input  logic [15:0] half_val,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (load_hi) begin
      pc[31:16] <= half_val;
    end else if (load_lo) begin
      pc[15:0] <= half_val;
    end else if (inc) begin
      pc <= pc + 32'd1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: boots PC from memory, assembles one/two-word instructions for IF_ID.
// Interrupt support is compiled in only when IF_STAGE_INT_EN is defined.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall_in,
  input  logic        jmp_in,
  input  logic [31:0] jmp_addr_in,
  input  logic        INT_in,
  output logic [31:0] PC_out,
  output logic [15:0] instruction_out,
  output logic [15:0] Data_out,
  output logic        INT_out,
  output logic        valid_out
);

  if_state_t   state, next_state;
  logic [31:0] pc;
  logic        pc_inc, pc_load, pc_load_hi, pc_load_lo;
  logic [15:0] latch, latch_n;
  logic [31:0] pc_out_n;
  logic [15:0] instr_n, data_n;
  logic        int_out_q, int_out_n, valid_n;

`ifdef IF_STAGE_INT_EN
  logic int_pending, int_prev, take_int;
`else
  logic unused_int_in;
  assign unused_int_in = INT_in;
`endif

  pc_reg u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_hi  (pc_load_hi),
    .load_lo  (pc_load_lo),
    .load_val (jmp_addr_in),
    .half_val (imem_data),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= BOOT0;
      latch           <= '0;
      PC_out          <= '0;
      instruction_out <= '0;
      Data_out        <= '0;
      int_out_q       <= 1'b0;
      valid_out       <= 1'b0;
    end else begin
      state           <= next_state;
      latch           <= latch_n;
      PC_out          <= pc_out_n;
      instruction_out <= instr_n;
      Data_out        <= data_n;
      int_out_q       <= int_out_n;
      valid_out       <= valid_n;
    end
  end

  assign INT_out = int_out_q;

`ifdef IF_STAGE_INT_EN
  // Edge detect keeps running under stall so a request is never lost; a new edge beats the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_prev    <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      int_prev <= INT_in;
      if (INT_in && !int_prev) begin
        int_pending <= 1'b1;
      end else if (take_int) begin
        int_pending <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    next_state = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_load_hi = 1'b0;
    pc_load_lo = 1'b0;
    imem_addr  = pc;
    latch_n    = latch;
    pc_out_n   = PC_out;
    instr_n    = instruction_out;
    data_n     = Data_out;
    int_out_n  = int_out_q;
    valid_n    = valid_out;
`ifdef IF_STAGE_INT_EN
    take_int   = 1'b0;
`endif

    unique case (state)
      BOOT0: begin
        imem_addr = RESET_VEC_ADDR;
        if (!stall_in) begin
          pc_load_hi = 1'b1;
          valid_n    = 1'b0;
          int_out_n  = 1'b0;
          next_state = BOOT1;
        end
      end
      BOOT1: begin
        imem_addr = RESET_VEC_ADDR + 32'd1;
        if (!stall_in) begin
          pc_load_lo = 1'b1;
          valid_n    = 1'b0;
          int_out_n  = 1'b0;
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (jmp_in) begin
          pc_load    = 1'b1;
          valid_n    = 1'b0;
          int_out_n  = 1'b0;
          next_state = FETCH;
        end else if (!stall_in) begin
`ifdef IF_STAGE_INT_EN
          if (int_pending) begin
            take_int   = 1'b1;
            pc_out_n   = pc;
            instr_n    = '0;
            data_n     = '0;
            int_out_n  = 1'b1;
            valid_n    = 1'b1;
            next_state = INT0;
          end else
`endif
          if (is_two_word(imem_data)) begin
            latch_n    = imem_data;
            pc_inc     = 1'b1;
            valid_n    = 1'b0;
            int_out_n  = 1'b0;
            next_state = FETCH_IMM;
          end else begin
            pc_out_n  = pc;
            instr_n   = imem_data;
            data_n    = '0;
            int_out_n = 1'b0;
            valid_n   = 1'b1;
            pc_inc    = 1'b1;
          end
        end
      end
      FETCH_IMM: begin
        if (jmp_in) begin
          pc_load    = 1'b1;
          valid_n    = 1'b0;
          int_out_n  = 1'b0;
          next_state = FETCH;
        end else if (!stall_in) begin
          pc_out_n   = pc - 32'd1;
          instr_n    = latch;
          data_n     = imem_data;
          int_out_n  = 1'b0;
          valid_n    = 1'b1;
          pc_inc     = 1'b1;
          next_state = FETCH;
        end
      end
`ifdef IF_STAGE_INT_EN
      INT0: begin
        imem_addr = INT_VEC_ADDR;
        if (!stall_in) begin
          pc_load_hi = 1'b1;
          valid_n    = 1'b0;
          int_out_n  = 1'b0;
          next_state = INT1;
        end
      end
      INT1: begin
        imem_addr = INT_VEC_ADDR + 32'd1;
        if (!stall_in) begin
          pc_load_lo = 1'b1;
          valid_n    = 1'b0;
          int_out_n  = 1'b0;
          next_state = FETCH;
        end
      end
`endif
      default: begin
        next_state = BOOT0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; interrupt vectors run when IF_STAGE_INT_EN is defined.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall_in;
  logic        jmp_in;
  logic [31:0] jmp_addr_in;
  logic        INT_in;
  logic [31:0] PC_out;
  logic [15:0] instruction_out;
  logic [15:0] Data_out;
  logic        INT_out;
  logic        valid_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] mem [logic [31:0]];
  int unsigned mem_gen = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall_in        (stall_in),
    .jmp_in          (jmp_in),
    .jmp_addr_in     (jmp_addr_in),
    .INT_in          (INT_in),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .Data_out        (Data_out),
    .INT_out         (INT_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(imem_addr or mem_gen) begin
    if (mem.exists(imem_addr)) imem_data = mem[imem_addr];
    else imem_data = 16'h0000;
  end

  task automatic mem_wr(input logic [31:0] a, input logic [15:0] d);
    mem[a] = d;
    mem_gen++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_emit(input string tag, input logic [31:0] pc, input logic [15:0] ins,
                            input logic [15:0] dat, input logic intr);
    check({tag, ".valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, ".pc"}, PC_out, pc);
    check({tag, ".instr"}, {16'd0, instruction_out}, {16'd0, ins});
    check({tag, ".data"}, {16'd0, Data_out}, {16'd0, dat});
    check({tag, ".int"}, {31'd0, INT_out}, {31'd0, intr});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, ".pc"}, PC_out, 32'd0);
    check({tag, ".instr"}, {16'd0, instruction_out}, 32'd0);
    check({tag, ".data"}, {16'd0, Data_out}, 32'd0);
    check({tag, ".int"}, {31'd0, INT_out}, 32'd0);
    check({tag, ".addr"}, imem_addr, 32'd0);
  endtask

  task automatic reboot(input string tag);
    @(negedge clk);
    reset = 1'b1;
    step();
    check({tag, ".boot1_addr"}, imem_addr, 32'd1);
    check({tag, ".boot1_valid"}, {31'd0, valid_out}, 32'd0);
    step();
    check({tag, ".first_fetch"}, imem_addr, 32'h20);
    check({tag, ".fetch_valid"}, {31'd0, valid_out}, 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    stall_in    = 1'b0;
    jmp_in      = 1'b0;
    jmp_addr_in = '0;
    INT_in      = 1'b0;
    mem_wr(32'h0, 16'h0000);
    mem_wr(32'h1, 16'h0020);
    mem_wr(32'h2, 16'h0000);
    mem_wr(32'h3, 16'h0300);
    mem_wr(32'h20, 16'h4123);
    mem_wr(32'h21, 16'hBEEF);
    mem_wr(32'h22, 16'h1111);
    mem_wr(32'h23, 16'h2222);
    mem_wr(32'h100, 16'h0ABC);
    mem_wr(32'h101, 16'h5000);
    mem_wr(32'h102, 16'hDEAD);
    mem_wr(32'hFFFF_FFFF, 16'h4ABC);
    mem_wr(32'h200, 16'h4001);
    mem_wr(32'h201, 16'h7777);
    mem_wr(32'h202, 16'h0202);
    mem_wr(32'h203, 16'h4000);
    mem_wr(32'h300, 16'h1300);
    mem_wr(32'h301, 16'h1301);
    mem_wr(32'h302, 16'h1302);

    #12;
    check_reset_state("reset");
    reboot("boot");

    // Two-word instruction at 0x20
    step();
    check("imm.fetch_imm_addr", imem_addr, 32'h21);
    check("imm.half_valid", {31'd0, valid_out}, 32'd0);
    step();
    check_emit("imm", 32'h20, 16'h4123, 16'hBEEF, 1'b0);
    check("imm.next_addr", imem_addr, 32'h22);

    step();
    check_emit("one", 32'h22, 16'h1111, 16'h0000, 1'b0);
    check("one.next_addr", imem_addr, 32'h23);

    // Stall freezes everything, then a jump during stall wins
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_emit("stall", 32'h22, 16'h1111, 16'h0000, 1'b0);
      check("stall.addr", imem_addr, 32'h23);
    end
    jmp_in      = 1'b1;
    jmp_addr_in = 32'h100;
    step();
    check("jmp.addr", imem_addr, 32'h100);
    check("jmp.valid", {31'd0, valid_out}, 32'd0);
    jmp_in   = 1'b0;
    stall_in = 1'b0;
    step();
    check_emit("jmp_tgt", 32'h100, 16'h0ABC, 16'h0000, 1'b0);

    // Jump during FETCH_IMM discards the half-fetched instruction
    step();
    check("half.addr", imem_addr, 32'h102);
    check("half.valid", {31'd0, valid_out}, 32'd0);
    jmp_in      = 1'b1;
    jmp_addr_in = 32'hFFFF_FFFF;
    step();
    check("abort.addr", imem_addr, 32'hFFFF_FFFF);
    check("abort.valid", {31'd0, valid_out}, 32'd0);
    jmp_in = 1'b0;

    // Two-word straddling the PC wrap
    step();
    check("wrap.imm_addr", imem_addr, 32'h0);
    check("wrap.valid", {31'd0, valid_out}, 32'd0);
    step();
    check_emit("wrap", 32'hFFFF_FFFF, 16'h4ABC, 16'h0000, 1'b0);
    check("wrap.next_addr", imem_addr, 32'h1);
    step();
    check_emit("after_wrap", 32'h1, 16'h0020, 16'h0000, 1'b0);

    // Two-word at 0x200 with an interrupt pulse while the immediate is fetched
    jmp_in      = 1'b1;
    jmp_addr_in = 32'h200;
    step();
    jmp_in = 1'b0;
    step();
    check("irq.imm_addr", imem_addr, 32'h201);
    INT_in = 1'b1;
    step();
    INT_in = 1'b0;
    check_emit("irq.two_word", 32'h200, 16'h4001, 16'h7777, 1'b0);
`ifdef IF_STAGE_INT_EN
    step();
    check_emit("irq.bubble", 32'h202, 16'h0000, 16'h0000, 1'b1);
    check("irq.int0_addr", imem_addr, 32'h2);
    step();
    check("irq.int1_addr", imem_addr, 32'h3);
    check("irq.int1_valid", {31'd0, valid_out}, 32'd0);
    check("irq.int1_intout", {31'd0, INT_out}, 32'd0);
    step();
    check("irq.vector", imem_addr, 32'h300);
    step();
    check_emit("irq.handler", 32'h300, 16'h1300, 16'h0000, 1'b0);

    // Second interrupt, reset asserted while in INT1
    INT_in = 1'b1;
    step();
    INT_in = 1'b0;
    check_emit("irq2.pre", 32'h301, 16'h1301, 16'h0000, 1'b0);
    step();
    check_emit("irq2.bubble", 32'h302, 16'h0000, 16'h0000, 1'b1);
    step();
    check("irq2.int1_addr", imem_addr, 32'h3);
    reset = 1'b0;
    #1;
    check_reset_state("reset_int1");
    reboot("reboot");
`else
    step();
    check_emit("noint.next", 32'h202, 16'h0202, 16'h0000, 1'b0);
    step();
    check("noint.imm_addr", imem_addr, 32'h204);
    check("noint.intout", {31'd0, INT_out}, 32'd0);
    reset = 1'b0;
    #1;
    check_reset_state("reset_fetch_imm");
    reboot("reboot");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock, clk, with an asynchronous active-low reset named reset; all state SHALL clear immediately while reset=0.
REQ-002 Ports SHALL be as follows:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  imem_addr  out  32  instruction-memory word address, combinational from PC/state
  imem_data  in  16  word read from imem_addr in the same cycle
  stall_in  in  1  hazard stall; hold PC, state and outputs
  jmp_in  in  1  taken jump/branch/RET redirect
  jmp_addr_in  in  32  redirect target
  INT_in  in  1  external interrupt request, level
  PC_out  out  32  address of first word of emitted instruction (return PC for INT)
  instruction_out  out  16  first instruction word
  Data_out  out  16  immediate word (0 for one-word instructions)
  INT_out  out  1  emitted slot is an interrupt bubble
  valid_out  out  1  outputs hold a complete instruction for IF_ID

Function
REQ-003 State machine: BOOT0, BOOT1, FETCH, FETCH_IMM, INT0, INT1.
REQ-004 BOOT0: imem_addr=0, PC[31:16]<=imem_data, go to BOOT1. BOOT1: imem_addr=1, PC[15:0]<=imem_data, go to FETCH. valid_out=0 in both.
REQ-005 FETCH: imem_addr=PC; two-word class is instr[15:13]==IMM_CLASS. One-word: register outputs, Data_out<=0, valid_out<=1, PC<=PC+1. Two-word: latch word, PC<=PC+1, valid_out<=0, go to FETCH_IMM.
REQ-006 FETCH_IMM: imem_addr=PC; Data_out<=imem_data, emit latched word with PC_out=PC-1, valid_out<=1, PC<=PC+1, go to FETCH.
REQ-007 Latency: one-word instruction at PC fetched in cycle n SHALL be valid on outputs after edge n; two-word after edge n+1.
REQ-008 PC arithmetic SHALL be 32-bit unsigned, wrapping 0xFFFFFFFF -> 0x00000000; a two-word instruction straddling the wrap SHALL fetch its immediate from address 0.
REQ-009 stall_in=1 (no jmp_in) SHALL freeze PC, state, latched word and all outputs.
REQ-010 jmp_in=1 SHALL, in FETCH/FETCH_IMM, set PC<=jmp_addr_in, discard any half-fetched instruction, drive valid_out<=0, go to FETCH; jmp_in overrides stall_in; jmp_in SHALL be ignored in BOOT0/BOOT1.
REQ-011 A rising INT_in SHALL set int_pending; it SHALL be taken only in FETCH with no jmp_in/stall_in, never mid two-word instruction.
REQ-012 Taking an interrupt: emit INT_out=1, valid_out=1, PC_out=PC (return address), instruction_out=0, Data_out=0; go to INT0; clear int_pending.
REQ-013 INT0: imem_addr=2, PC[31:16]<=imem_data. INT1: imem_addr=3, PC[15:0]<=imem_data, go to FETCH. valid_out=0, INT_out=0 in both; jmp_in ignored.
REQ-014 Simultaneous jmp_in and pending interrupt in FETCH: jump first, interrupt stays pending and is taken at the next FETCH cycle.
REQ-015 INT_out SHALL be high for exactly one valid cycle per interrupt.

Reset
REQ-016 On reset=0: state=BOOT0, PC=0, latched word=0, int_pending=0, PC_out=0, instruction_out=0, Data_out=0, INT_out=0, valid_out=0.
REQ-017 Reset asserted mid-operation (any state, including FETCH_IMM or INT1) SHALL abort it; after release, boot restarts from address 0.

Configuration
REQ-018 Macro IF_STAGE_INT_EN defined: interrupt logic per REQ-011..015 present.
REQ-019 Macro undefined: INT0/INT1 and int_pending absent, INT_in ignored, INT_out tied 0; all other behaviour identical.

Structure
REQ-020 Shared package SHALL hold state encoding, IMM_CLASS (3'b010), RESET_VEC_ADDR (0) and INT_VEC_ADDR (2).
REQ-021 One sub-module, pc_reg (32-bit PC with load/increment/hold), SHALL be instantiated; the FSM stays in if_stage.

Verification
REQ-022 Boot: M[0]=0x0000, M[1]=0x0020 -> PC=0x20 after two cycles; first fetch imem_addr=0x20.
REQ-023 Two-word: M[0x20]=0x4xxx class, M[0x21]=0xBEEF -> one valid_out pulse, PC_out=0x20, Data_out=0xBEEF, next fetch at 0x22.
REQ-024 Stall plus jump: stall_in=1 for 3 cycles -> outputs frozen; jmp_in=1, jmp_addr_in=0x100 during stall -> next fetch at 0x100, valid_out=0.
REQ-025 Interrupt: INT_in pulse during FETCH_IMM, M[2]=0, M[3]=0x300 -> two-word completes, then INT_out=1 with PC_out=return PC, then fetch at 0x300.
REQ-026 Wrap and reset: PC=0xFFFFFFFF two-word -> immediate read from address 0; reset=0 in INT1 -> all outputs 0, reboot from M[0].
